// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like bus between instruction fetch and data access, routing in-order responses by owner tag.
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin arbitration (default: data over inst).
module sram_bus_arbiter #(
  parameter int MAX_OUTST = 2,
  parameter int IDW       = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam logic [IDW-1:0] TAG_I = '0;
  localparam logic [IDW-1:0] TAG_D = IDW'(1);

  typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_D} state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   tag_q [MAX_OUTST];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req, sel_data, win_data, push, pop, full, head_is_data;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTST - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A response arriving this cycle frees its slot for this cycle's grant.
  assign pop  = !reset && bus_data_ok && (cnt_q != '0);
  assign full = (cnt_q == CNT_W'(MAX_OUTST)) && !bus_data_ok;

`ifdef ARB_ROUND_ROBIN_EN
  // rr_q=1 means data holds priority on the next conflict.
  logic rr_q, rr_d;
  assign win_data = (inst_req && data_req) ? rr_q : data_req;
  assign rr_d     = push ? ~sel_data : rr_q;

  always_ff @(posedge clk) begin
    if (reset) rr_q <= 1'b0;
    else       rr_q <= rr_d;
  end
`else
  assign win_data = data_req;
`endif

  always_comb begin
    state_d  = state_q;
    req      = 1'b0;
    sel_data = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!full && (inst_req || data_req)) begin
          req      = 1'b1;
          sel_data = win_data;
          if (!bus_addr_ok) state_d = win_data ? LOCK_D : LOCK_I;
        end
      end
      LOCK_I: begin
        req = 1'b1;
        if (bus_addr_ok) state_d = IDLE;
      end
      LOCK_D: begin
        req      = 1'b1;
        sel_data = 1'b1;
        if (bus_addr_ok) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (reset) req = 1'b0;
  end

  assign push     = req && bus_addr_ok;
  assign cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
  assign wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
  assign rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) tag_q[wr_ptr_q] <= sel_data ? TAG_D : TAG_I;
  end

  assign head_is_data = (tag_q[rd_ptr_q] == TAG_D);

  assign bus_req      = req;
  assign bus_wr       = req && sel_data && data_wr;
  assign bus_size     = !req ? 2'd0 : (sel_data ? data_size : 2'd2);
  assign bus_wstrb    = (req && sel_data) ? data_wstrb : 4'h0;
  assign bus_addr     = !req ? 32'h0 : (sel_data ? data_addr : inst_addr);
  assign bus_wdata    = (req && sel_data) ? data_wdata : 32'h0;

  assign inst_addr_ok = push && !sel_data;
  assign data_addr_ok = push && sel_data;
  assign inst_data_ok = pop && !head_is_data;
  assign data_data_ok = pop && head_is_data;
  assign inst_rdata   = bus_rdata;
  assign data_rdata   = bus_rdata;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Scoreboard bench for sram_bus_arbiter: directed scenarios followed by randomized traffic.
module tb_sram_bus_arbiter;
  localparam int MAX_OUTST = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok;
  logic [1:0]  bus_size;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  typedef struct packed {
    logic        own;    // 0 = inst, 1 = data
    logic [31:0] rdata;
  } rsp_t;

  rsp_t        exp_q[$];   // responses owed to the pipeline, in issue order
  logic        outst[$];   // model's view of outstanding owners
  int          lock_own;   // -1 when no request is pinned to the bus
`ifdef ARB_ROUND_ROBIN_EN
  logic        prio;       // 1 = data wins the next conflict
`endif
  logic [31:0] next_rdata; // data the bus slave will return for the next accepted request
  logic        i_acc, d_acc;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  sram_bus_arbiter #(.MAX_OUTST(MAX_OUTST), .IDW(1)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
    .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: arbitration rules applied to an owner queue, checked every cycle.
  always @(negedge clk) begin : model
    logic popping, room, exp_req, own;
    if (reset) begin
      chk("reset_outputs", {bus_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 128'h0);
      outst.delete();
      exp_q.delete();
      lock_own = -1;
`ifdef ARB_ROUND_ROBIN_EN
      prio = 1'b0;
`endif
    end else begin
      popping = bus_data_ok && (outst.size() > 0);
      room    = (outst.size() < MAX_OUTST) || popping;
      exp_req = 1'b0;
      own     = 1'b0;
      if (lock_own >= 0) begin
        exp_req = 1'b1;
        own     = (lock_own == 1);
      end else if (room && (inst_req || data_req)) begin
        exp_req = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
        own = (inst_req && data_req) ? prio : data_req;
`else
        own = data_req;
`endif
      end
      chk("grant", {bus_req, inst_addr_ok, data_addr_ok},
          {exp_req, exp_req && bus_addr_ok && !own, exp_req && bus_addr_ok && own});
      if (exp_req && own)
        chk("bus_data_fields", {bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata},
            {data_wr, data_size, data_wstrb, data_addr, data_wdata});
      else if (exp_req)
        chk("bus_inst_fields", {bus_wr, bus_size, bus_wstrb, bus_addr}, {1'b0, 2'd2, 4'h0, inst_addr});
      if (popping) void'(outst.pop_front());
      if (exp_req && bus_addr_ok) begin
        outst.push_back(own);
        exp_q.push_back({own, next_rdata});
        lock_own = -1;
`ifdef ARB_ROUND_ROBIN_EN
        prio = !own;
`endif
      end else if (exp_req) begin
        lock_own = own ? 1 : 0;
      end
    end
  end

  // Response monitor: every bus response must reach the owner at the head of the scoreboard.
  always @(negedge clk) begin : monitor
    rsp_t r;
    if (!reset) begin
      if (bus_data_ok && (exp_q.size() > 0)) begin
        r = exp_q.pop_front();
        chk("rsp_owner", {inst_data_ok, data_data_ok}, {!r.own, r.own});
        chk("rsp_rdata", r.own ? data_rdata : inst_rdata, r.rdata);
      end else begin
        chk("no_rsp", {inst_data_ok, data_data_ok}, 128'h0);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    i_acc = inst_addr_ok;
    d_acc = data_addr_ok;
    @(posedge clk);
    #1;
    if (i_acc) inst_req = 1'b0;
    if (d_acc) data_req = 1'b0;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    bus_rdata   = $urandom;
    next_rdata  = $urandom;
  endtask

  task automatic respond();
    bus_data_ok = 1'b1;
    if (exp_q.size() > 0) bus_rdata = exp_q[0].rdata;
    else                  bus_rdata = $urandom;
  endtask

  task automatic raise_i(input logic [31:0] a);
    inst_req  = 1'b1;
    inst_addr = a;
  endtask

  task automatic raise_d(input logic wr, input logic [1:0] sz, input logic [3:0] st,
                         input logic [31:0] a, input logic [31:0] wd);
    data_req   = 1'b1;
    data_wr    = wr;
    data_size  = sz;
    data_wstrb = st;
    data_addr  = a;
    data_wdata = wd;
  endtask

  task automatic do_reset(input int n);
    reset       = 1'b1;
    inst_req    = 1'b0;
    data_req    = 1'b0;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] ra;
    reset = 1'b1;
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_size = '0; data_wstrb = '0; data_addr = '0; data_wdata = '0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0; next_rdata = '0;
    do_reset(3);

    // Single fetch: accepted in cycle 0, answered in cycle 2.
    raise_i(32'h1c00_0000);
    next_rdata  = 32'h0280_0c0c;
    bus_addr_ok = 1'b1;
    tick(); tick();
    respond(); tick();

    // Simultaneous fetch and store.
    raise_i(32'h1c00_0004);
    raise_d(1'b1, 2'd2, 4'hF, 32'h8000_1000, 32'hcafe_f00d);
    bus_addr_ok = 1'b1; tick();
    bus_addr_ok = 1'b1; tick();
    respond(); tick();
    respond(); tick();

    // Data request locked while the bus stalls; fetch arrives in cycle 1.
    raise_d(1'b0, 2'd1, 4'h0, 32'h8000_2002, 32'h0);
    tick();
    raise_i(32'h1c00_0008);
    tick(); tick();
    bus_addr_ok = 1'b1; tick();
    bus_addr_ok = 1'b1; tick();
    respond(); tick();
    respond(); tick();

    // Two outstanding: third request held off until a response frees a slot.
    raise_i(32'h1c00_0010); bus_addr_ok = 1'b1; tick();
    raise_d(1'b0, 2'd0, 4'h0, 32'h8000_3001, 32'h0); bus_addr_ok = 1'b1; tick();
    raise_i(32'h1c00_0014); bus_addr_ok = 1'b1; tick();
    bus_addr_ok = 1'b1; respond(); tick();
    respond(); tick();
    respond(); tick();

    // Reset with one outstanding, followed by a stray response.
    raise_i(32'h1c00_0018); bus_addr_ok = 1'b1; tick();
    do_reset(2);
    respond(); tick();
    tick();

    // Continuous requests from both sides with immediate acceptance.
    repeat (10) begin
      ra = $urandom;
      if (!inst_req) raise_i(ra & 32'hffff_fffc);
      if (!data_req) raise_d(ra[0], 2'd2, 4'hF, ra ^ 32'h8000_0000, ~ra);
      bus_addr_ok = 1'b1;
      if (exp_q.size() > 0) respond();
      tick();
    end

    // Randomized traffic with occasional resets.
    repeat (4000) begin
      if ($urandom_range(0, 399) == 0) do_reset(2);
      ra = $urandom;
      if (!inst_req && ($urandom_range(0, 99) < 40)) raise_i(ra & 32'hffff_fffc);
      ra = $urandom;
      if (!data_req && ($urandom_range(0, 99) < 40))
        raise_d(ra[31], 2'($urandom_range(0, 2)), 4'($urandom), ra, $urandom);
      bus_addr_ok = ($urandom_range(0, 99) < 60);
      if ((exp_q.size() > 0) && ($urandom_range(0, 99) < 45)) respond();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
